instr_fetch_seq: RTL and testbench

- Instruction-side sequencer. It is the producer end of the opcode interface consumed by the multi-cycle control unit.
- Holds the PC and fetches from the synchronous instruction memory. Latches the instruction word and presents `opcode`/`instr` for a fixed-length execution frame.
- At frame end, computes the next PC from the control unit's PC-mux select (`pc_sel`, codes 0-4) and the ALU flags `equ`/`les`.
- Frame cadence matches the control unit's 8-cycle decode period.

---
 rtl/instr_fetch_seq.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction-side sequencer: owns the PC, fetches from synchronous instruction
// memory and presents one opcode per fixed-length frame to the control unit.
module instr_fetch_seq #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  FRAME_LEN   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [5:0]             opcode,
  output logic                   frame_start,
  input  logic [2:0]             pc_sel,
  input  logic [PC_WIDTH-1:0]    reg_target,
  input  logic                   equ,
  input  logic                   les,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic                   sel_err
);

  localparam int                PH_W    = $clog2(FRAME_LEN);
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    FETCH,
    LATCH,
    EXEC,
    UPDATE,
    HALT
  } state_t;

  state_t                 state_reg, state_next;
  logic [PH_W-1:0]        phase_reg, phase_next;
  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [PC_WIDTH-1:0]    addr_reg, addr_next;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
  logic                   frame_start_reg, frame_start_next;
  logic                   halted_reg, halted_next;
  logic                   sel_err_reg, sel_err_next;

  logic [5:0]             op;
  logic [PC_WIDTH-1:0]    imm_ext;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    target_pc;

  function automatic state_t phase_state(input logic [PH_W-1:0] p);
    if (p == '0)
      return FETCH;
    else if (p == PH_W'(1))
      return LATCH;
    else if (p == PH_LAST)
      return UPDATE;
    return EXEC;
  endfunction

  // Branch offset is relative to the instruction after the branch.
  assign op            = instr_reg[INSTR_WIDTH-1 -: 6];
  assign imm_ext       = PC_WIDTH'($signed(instr_reg[15:0]));
  assign pc_inc        = pc_reg + PC_WIDTH'(1);
  assign branch_target = pc_inc + imm_ext;
  assign branch_taken  = ((op == 6'd30) && equ) || ((op == 6'd31) && les);

  always_comb begin
    case (pc_sel)
      3'd0:    target_pc = instr_reg[PC_WIDTH-1:0];
      3'd1:    target_pc = branch_taken ? branch_target : pc_inc;
      3'd2:    target_pc = reg_target;
      3'd4:    target_pc = pc_reg;
      default: target_pc = pc_inc;
    endcase
  end

  always_comb begin
    phase_next       = phase_reg;
    pc_next          = pc_reg;
    addr_next        = addr_reg;
    instr_next       = instr_reg;
    frame_start_next = 1'b0;
    halted_next      = halted_reg;
    sel_err_next     = sel_err_reg;

    case (state_reg)
      FETCH: begin
        addr_next  = pc_reg;
        phase_next = phase_reg + PH_W'(1);
      end
      LATCH: begin
        instr_next = imem_rdata;
        phase_next = phase_reg + PH_W'(1);
      end
      EXEC: begin
        // Registered pulse lands in the cycle after phase 2.
        frame_start_next = (phase_reg == PH_W'(2));
        phase_next       = phase_reg + PH_W'(1);
      end
      UPDATE: begin
        phase_next = '0;
        pc_next    = target_pc;
        addr_next  = target_pc;
        if (pc_sel == 3'd4)
          halted_next = 1'b1;
        if (pc_sel > 3'd4)
          sel_err_next = 1'b1;
      end
      default: begin
        // HALT: everything frozen until reset.
      end
    endcase

    state_next = halted_next ? HALT : phase_state(phase_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= FETCH;
      phase_reg       <= '0;
      pc_reg          <= RESET_PC;
      addr_reg        <= RESET_PC;
      instr_reg       <= '0;
      frame_start_reg <= 1'b0;
      halted_reg      <= 1'b0;
      sel_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      pc_reg          <= pc_next;
      addr_reg        <= addr_next;
      instr_reg       <= instr_next;
      frame_start_reg <= frame_start_next;
      halted_reg      <= halted_next;
      sel_err_reg     <= sel_err_next;
    end
  end

  assign imem_addr   = addr_reg;
  assign instr       = instr_reg;
  assign opcode      = instr_reg[INSTR_WIDTH-1 -: 6];
  assign frame_start = frame_start_reg;
  assign pc          = pc_reg;
  assign halted      = halted_reg;
  assign sel_err     = sel_err_reg;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: a frame-level model predicts every output
// each cycle, and literal PC / pulse-timing expectations pin the model itself.
module tb_instr_fetch_seq;
  localparam int PW = 16;
  localparam int IW = 32;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr;
  logic [5:0]    opcode;
  logic          frame_start;
  logic [2:0]    pc_sel = 3'd3;
  logic [PW-1:0] reg_target = '0;
  logic          equ = 1'b0;
  logic          les = 1'b0;
  logic [PW-1:0] pc;
  logic          halted;
  logic          sel_err;

  always #5 clk = ~clk;

  instr_fetch_seq #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .FRAME_LEN  (FL),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .frame_start(frame_start),
    .pc_sel     (pc_sel),
    .reg_target (reg_target),
    .equ        (equ),
    .les        (les),
    .pc         (pc),
    .halted     (halted),
    .sel_err    (sel_err)
  );

  // Synchronous instruction memory, one-cycle read latency.
  bit [31:0] mem [0:65535];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // Frame-level model: cyc counts edges since reset; the word at pc is taken
  // in frame cycle 1 and the PC moves at the last cycle of the frame.
  int        cyc;
  int        m_pc;
  bit [31:0] m_instr;
  bit        m_halt;
  bit        m_err;
  int        m_op, m_imm, m_np;

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; m_pc = 0; m_instr = 0; m_halt = 0; m_err = 0;
    end else begin
      if (!m_halt) begin
        if (cyc % FL == 1)
          m_instr = mem[m_pc];
        else if (cyc % FL == FL - 1) begin
          m_op = int'(m_instr[31:26]);
          case (pc_sel)
            3'd0: m_np = int'(m_instr[15:0]);
            3'd1: begin
              m_imm = int'(m_instr[15:0]);
              if (m_imm >= 32768) m_imm = m_imm - 65536;
              if ((m_op == 30 && equ) || (m_op == 31 && les))
                m_np = m_pc + 1 + m_imm;
              else
                m_np = m_pc + 1;
            end
            3'd2: m_np = int'(reg_target);
            3'd3: m_np = m_pc + 1;
            3'd4: begin m_np = m_pc; m_halt = 1; end
            default: begin m_np = m_pc + 1; m_err = 1; end
          endcase
          m_pc = m_np & 32'h0000FFFF;
        end
      end
      cyc++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int fs_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle the bench advances, all outputs are compared against the model.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("pc",          32'(pc),          32'(m_pc[15:0]));
      check("imem_addr",   32'(imem_addr),   32'(m_pc[15:0]));
      check("instr",       instr,            m_instr);
      check("opcode",      32'(opcode),      32'(m_instr[31:26]));
      check("frame_start", 32'(frame_start), 32'(!m_halt && (cyc % FL == 3)));
      check("halted",      32'(halted),      32'(m_halt));
      check("sel_err",     32'(sel_err),     32'(m_err));
      if (frame_start === 1'b1) fs_log.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1;
    tick();
    rst_n = 1'b1;
    fs_log.delete();
  endtask

  // Runs one frame starting at phase 0; optional noise on the UPDATE-only
  // inputs during EXEC must not change the outcome.
  task automatic frame(input logic [2:0] sel, input logic e, input logic l,
                       input logic [15:0] tgt, input bit noise, input logic [15:0] exp_pc);
    logic [15:0] start_pc;
    start_pc = pc;
    pc_sel = sel; equ = e; les = l; reg_target = tgt;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      if (noise && (cyc % FL == 2)) begin
        pc_sel = 3'd4; equ = ~e; les = ~l; reg_target = 16'h1234;
      end else if (noise && (cyc % FL == 6)) begin
        pc_sel = sel; equ = e; les = l; reg_target = tgt;
      end
      if (cyc % FL == 0) break;
    end
    check("frame_end_reached", 32'(cyc % FL), 32'd0);
    check("frame_pc", 32'(pc), 32'(exp_pc));
    $display("frame pc=%h sel=%0d equ=%0d les=%0d tgt=%h -> pc=%h sel_err=%0d halted=%0d",
             start_pc, sel, e, l, tgt, pc, sel_err, halted);
  endtask

  function automatic int fs_at(input int k);
    return (fs_log.size() > k) ? fs_log[k] : -1;
  endfunction

  initial begin
    int fs_cnt;
    int seen;
    mem[16'h0000] = {6'd1, 26'h0000005};
    mem[16'h0001] = {6'd1, 26'h0000000};
    mem[16'h0002] = {6'd1, 26'h0000000};
    mem[16'h0003] = {6'd1, 26'h0000000};
    mem[16'h0004] = {6'd2, 26'h0000010};
    mem[16'h0005] = {6'd9, 26'h0000123};
    mem[16'h000D] = {6'd2, 26'h0000010};
    mem[16'h0010] = {6'd30, 10'd0, 16'hFFFC};
    mem[16'h0011] = {6'd2, 26'h0000010};
    mem[16'h0016] = {6'd5, 26'h0000100};

    do_reset();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    // Sequential fetch and pulse cadence.
    frame(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0001);
    frame(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0002);
    frame(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0003);
    frame(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0004);
    check("fs_cycle0", 32'(fs_at(0)), 32'd3);
    check("fs_cycle1", 32'(fs_at(1)), 32'd11);
    check("fs_cycle2", 32'(fs_at(2)), 32'd19);
    check("fs_cycle3", 32'(fs_at(3)), 32'd27);

    // Absolute jump, conditional branches.
    frame(3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0010);
    frame(3'd1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h000D);
    frame(3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0010);
    frame(3'd1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0011);
    mem[16'h0010] = {6'd31, 10'd0, 16'h0005};
    frame(3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0010);
    frame(3'd1, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0016);

    // Jumps, jump-register with EXEC-phase noise.
    frame(3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0100);
    frame(3'd2, 1'b0, 1'b0, 16'h0ABC, 1'b0, 16'h0ABC);
    frame(3'd2, 1'b0, 1'b0, 16'h0200, 1'b1, 16'h0200);

    // Illegal select and stickiness.
    frame(3'd6, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0201);
    check("sel_err_set", 32'(sel_err), 32'h1);
    frame(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0202);
    check("sel_err_sticky", 32'(sel_err), 32'h1);

    // PC wrap.
    frame(3'd2, 1'b0, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF);
    frame(3'd3, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0000);

    // Halt, then ignore inputs for 40 cycles.
    frame(3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0005);
    frame(3'd4, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0005);
    check("halt_set", 32'(halted), 32'h1);
    fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      pc_sel = 3'($urandom_range(0, 7));
      equ = 1'($urandom_range(0, 1));
      les = 1'($urandom_range(0, 1));
      reg_target = 16'($urandom);
      tick();
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("halt_no_fs", 32'(fs_cnt), 32'd0);
    check("halt_pc", 32'(pc), 32'h0005);

    do_reset();
    check("rst2_pc", 32'(pc), 32'h0);
    check("rst2_halted", 32'(halted), 32'h0);
    check("rst2_sel_err", 32'(sel_err), 32'h0);

    // Reset in the middle of a frame.
    frame(3'd0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0005);
    pc_sel = 3'd3;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      if (cyc % FL == 4) break;
    end
    check("mid_phase4", 32'(cyc % FL), 32'd4);
    check("mid_instr_before", instr, {6'd9, 26'h0000123});
    do_reset();
    check("mid_rst_pc", 32'(pc), 32'h0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_fs", 32'(frame_start), 32'h0);
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      tick();
      if (fs_log.size() > 0) seen = 1;
    end
    check("mid_first_fs", 32'(fs_at(0)), 32'd3);
    check("mid_pc_kept", 32'(pc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
